// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: opcode encodings, fetch FSM states
// and field widths.
package fetch_stage_pkg;

   localparam int ADDR_W   = 32;
   localparam int INSTR_W  = 16;
   localparam int OPCODE_W = 5;

   localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00000;
   localparam logic [OPCODE_W-1:0] OP_HLT  = 5'b00001;
   localparam logic [OPCODE_W-1:0] OP_LDM  = 5'b01001;
   localparam logic [OPCODE_W-1:0] OP_IADD = 5'b11010;
   localparam logic [OPCODE_W-1:0] OP_LDD  = 5'b01010;
   localparam logic [OPCODE_W-1:0] OP_STD  = 5'b01100;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b11001;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_IMM   = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational opcode classifier: flags two-word instructions (which carry an
// immediate word) and the halt instruction.
module fetch_predecode
   import fetch_stage_pkg::*;
(
   input  logic [OPCODE_W-1:0] opcode_i,
   output logic                is_two_word_o,
   output logic                is_halt_o
);

   assign is_two_word_o = (opcode_i == OP_LDM) || (opcode_i == OP_IADD);
   assign is_halt_o     = (opcode_i == OP_HLT);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives PC to external instruction memory, assembles
// one- and two-word instructions into the IF/ID register, handles stall/redirect/halt.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0020
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               redirect_en,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [INSTR_W-1:0] if_id_imm,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic               halted
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
   logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
   logic               vld_q, vld_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [INSTR_W-1:0] imm_q, imm_d;
   logic [ADDR_W-1:0]  ipc_q, ipc_d;

   logic is_two_word, is_halt;

   fetch_predecode u_predecode (
      .opcode_i      (imem_data[INSTR_W-1 -: OPCODE_W]),
      .is_two_word_o (is_two_word),
      .is_halt_o     (is_halt)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      vld_d        = vld_q;
      instr_d      = instr_q;
      imm_d        = imm_q;
      ipc_d        = ipc_q;

      // Redirect outranks stall; the half-assembled instruction is dropped.
      if (redirect_en) begin
         pc_d         = redirect_pc;
         state_d      = ST_FETCH;
         vld_d        = 1'b0;
         hold_instr_d = '0;
         hold_pc_d    = '0;
      end else if (!stall) begin
         case (state_q)
            ST_FETCH: begin
               if (is_halt) begin
                  vld_d   = 1'b1;
                  instr_d = imem_data;
                  imm_d   = '0;
                  ipc_d   = pc_q;
                  state_d = ST_HALT;
               end else if (is_two_word) begin
                  hold_instr_d = imem_data;
                  hold_pc_d    = pc_q;
                  pc_d         = pc_q + 1'b1;
                  vld_d        = 1'b0;
                  state_d      = ST_IMM;
               end else begin
                  vld_d   = 1'b1;
                  instr_d = imem_data;
                  imm_d   = '0;
                  ipc_d   = pc_q;
                  pc_d    = pc_q + 1'b1;
               end
            end
            ST_IMM: begin
               vld_d   = 1'b1;
               instr_d = hold_instr_q;
               imm_d   = imem_data;
               ipc_d   = hold_pc_q;
               pc_d    = pc_q + 1'b1;
               state_d = ST_FETCH;
            end
            ST_HALT: begin
               vld_d = 1'b0;
            end
            default: begin
               state_d = ST_FETCH;
               vld_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
         vld_q        <= 1'b0;
         instr_q      <= '0;
         imm_q        <= '0;
         ipc_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
         vld_q        <= vld_d;
         instr_q      <= instr_d;
         imm_q        <= imm_d;
         ipc_q        <= ipc_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_id_valid = vld_q;
   assign if_id_instr = instr_q;
   assign if_id_imm   = imm_q;
   assign if_id_pc    = ipc_q;
   assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized stall/redirect/reset traffic compared every cycle to a behavioural model.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr;
   logic [15:0] imem_data;
   logic        if_id_valid;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_imm;
   logic [31:0] if_id_pc;
   logic        halted;

   logic [15:0] mem [256];
   assign imem_data = mem[imem_addr[7:0]];

   int chk_cnt  = 0;
   int pass_cnt = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0020)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .if_id_valid (if_id_valid),
      .if_id_instr (if_id_instr),
      .if_id_imm   (if_id_imm),
      .if_id_pc    (if_id_pc),
      .halted      (halted)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: a PC, an optional pending first word, and a halted flag.
   logic [31:0] m_pc, m_hpc, m_ipc;
   logic [15:0] m_hw, m_instr, m_imm, w;
   bit          m_pend, m_halt, m_vld, m_rst;

   always @(posedge clk) begin
      m_rst = 1'b0;
      if (reset) begin
         m_pc = 32'h20; m_pend = 0; m_halt = 0; m_vld = 0;
         m_instr = 0; m_imm = 0; m_ipc = 0; m_rst = 1'b1;
      end else if (redirect_en) begin
         m_pc = redirect_pc; m_pend = 0; m_halt = 0; m_vld = 0;
      end else if (stall) begin
         // everything holds
      end else if (m_halt) begin
         m_vld = 0;
      end else if (m_pend) begin
         m_vld = 1; m_instr = m_hw; m_imm = mem[m_pc[7:0]]; m_ipc = m_hpc;
         m_pc = m_pc + 1; m_pend = 0;
      end else begin
         w = mem[m_pc[7:0]];
         if (w[15:11] == OP_LDM || w[15:11] == OP_IADD) begin
            m_hw = w; m_hpc = m_pc; m_pc = m_pc + 1; m_pend = 1; m_vld = 0;
         end else begin
            m_vld = 1; m_instr = w; m_imm = 0; m_ipc = m_pc;
            if (w[15:11] == OP_HLT) m_halt = 1;
            else m_pc = m_pc + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("addr", imem_addr, m_pc);
         check("halted", {31'b0, halted}, {31'b0, m_halt});
         check("valid", {31'b0, if_id_valid}, {31'b0, m_vld});
         if (m_vld || m_rst) begin
            check("instr", {16'b0, if_id_instr}, {16'b0, m_instr});
            check("imm", {16'b0, if_id_imm}, {16'b0, m_imm});
            check("pc", if_id_pc, m_ipc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall = 1'b0; redirect_en = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   endtask

   function automatic logic [15:0] rand_word();
      logic [4:0] op;
      case ($urandom_range(0, 9))
         0: op = OP_NOP;
         1: op = ($urandom_range(0, 3) == 0) ? OP_HLT : OP_ADD;
         2: op = OP_LDM;
         3: op = OP_IADD;
         4: op = OP_LDD;
         5: op = OP_STD;
         6: op = OP_ADD;
         default: op = 5'($urandom_range(0, 31));
      endcase
      return {op, 11'($urandom())};
   endfunction

   initial begin
      clear_mem();
      mem[8'h20] = 16'b01100_001_010_11111;
      tick();
      chk_en = 1'b1;
      // reset values
      check("rst_valid", {31'b0, if_id_valid}, 32'd0);
      check("rst_addr", imem_addr, 32'h20);
      check("rst_instr", {16'b0, if_id_instr}, 32'd0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      reset = 1'b0;
      tick();
      check("w1_valid", {31'b0, if_id_valid}, 32'd1);
      check("w1_instr", {16'b0, if_id_instr}, 32'h615F);
      check("w1_pc", if_id_pc, 32'h20);
      check("w1_addr", imem_addr, 32'h21);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_addr", imem_addr, 32'h21);
         check("stall_instr", {16'b0, if_id_instr}, 32'h615F);
      end
      stall = 1'b0;
      tick();
      check("resume_pc", if_id_pc, 32'h21);
      check("resume_addr", imem_addr, 32'h22);

      // two-word instruction
      mem[8'h20] = 16'h4900; mem[8'h21] = 16'h1234;
      do_reset();
      tick();
      check("ldm_c1_valid", {31'b0, if_id_valid}, 32'd0);
      check("ldm_c1_addr", imem_addr, 32'h21);
      tick();
      check("ldm_c2_valid", {31'b0, if_id_valid}, 32'd1);
      check("ldm_c2_instr", {16'b0, if_id_instr}, 32'h4900);
      check("ldm_c2_imm", {16'b0, if_id_imm}, 32'h1234);
      check("ldm_c2_pc", if_id_pc, 32'h20);

      // redirect during IMM, with stall also asserted
      do_reset();
      tick();
      redirect_en = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
      mem[8'h40] = 16'h6000;
      tick();
      redirect_en = 1'b0; stall = 1'b0;
      check("redir_valid", {31'b0, if_id_valid}, 32'd0);
      check("redir_addr", imem_addr, 32'h40);
      tick();
      check("redir_next_pc", if_id_pc, 32'h40);
      check("redir_next_instr", {16'b0, if_id_instr}, 32'h6000);
      check("redir_next_imm", {16'b0, if_id_imm}, 32'h0);

      // reset in the middle of IMM
      do_reset();
      tick();
      reset = 1'b1; stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h77;
      tick();
      reset = 1'b0; stall = 1'b0; redirect_en = 1'b0;
      check("rst_imm_valid", {31'b0, if_id_valid}, 32'd0);
      check("rst_imm_addr", imem_addr, 32'h20);

      // halt then redirect out
      clear_mem();
      mem[8'h22] = 16'h0800;
      do_reset();
      tick(); tick(); tick();
      check("hlt_valid", {31'b0, if_id_valid}, 32'd1);
      check("hlt_instr", {16'b0, if_id_instr}, 32'h0800);
      check("hlt_halted", {31'b0, halted}, 32'd1);
      check("hlt_addr", imem_addr, 32'h22);
      tick(); tick();
      check("hlt_hold_valid", {31'b0, if_id_valid}, 32'd0);
      check("hlt_hold_addr", imem_addr, 32'h22);
      redirect_en = 1'b1; redirect_pc = 32'h30;
      tick();
      redirect_en = 1'b0;
      check("hlt_exit_halted", {31'b0, halted}, 32'd0);
      check("hlt_exit_addr", imem_addr, 32'h30);
      tick();
      check("hlt_exit_pc", if_id_pc, 32'h30);

      // PC wrap
      redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      tick();
      redirect_en = 1'b0;
      tick();
      check("wrap_pc", if_id_pc, 32'hFFFF_FFFF);
      check("wrap_addr", imem_addr, 32'h0);

      // randomized traffic
      for (int i = 0; i < 256; i++) mem[i] = rand_word();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset       = ($urandom_range(0, 99) == 0);
         redirect_en = ($urandom_range(0, 15) == 0);
         stall       = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         else redirect_pc = 32'($urandom_range(0, 255));
         tick();
      end
      reset = 1'b0; redirect_en = 1'b0; stall = 1'b0;
      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
